cam_i2c_init_sequencer: RTL

// - Sequences power-up configuration of a MIPI CSI-2 camera sensor (CSI0/CSI1/CRUVI-HSX) over the fabric I2C mux bus.
// - Pulses the sensor reset, then walks a command table (register write / delay / end).
// - Each write is issued to a byte-level I2C master engine through a valid/ready command and response handshake.
// - Sits between the Platform Designer control CSR (start/status) and the shared fabric I2C master.

---
 rtl/cam_i2c_init_sequencer_if.sv | 23 ++
 rtl/cam_i2c_init_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_i2c_init_sequencer_if.sv
// Command/response handshake between the init sequencer and the byte-level I2C master engine.
// The sequencer side uses modport master; the engine side uses modport slave.
interface cam_i2c_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [6:0]  cmd_dev;
    logic [15:0] cmd_reg;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_nack;
    logic [7:0]  rsp_rdata;

    modport master (
        output cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
    );
endinterface

// File: rtl/cam_i2c_init_sequencer.sv
// Camera sensor power-up sequencer: pulses cam_reset_n, then walks a WR/DLY/END command table over I2C.
// Optional macro CAM_INIT_READBACK_EN adds a read-back verify of every acked register write.
module cam_i2c_init_sequencer #(
    parameter int         NUM_ENTRIES = 64,
    parameter int         IDX_W       = 6,
    parameter logic [6:0] DEV_ADDR    = 7'h36,
    parameter int         TICK_CYC    = 25000,
    parameter int         RESET_TICKS = 10,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [IDX_W-1:0]        err_index,
    output logic                    cam_reset_n,
    output logic [IDX_W-1:0]        tbl_addr,
    input  logic [31:0]             tbl_data,
    cam_i2c_init_sequencer_if.master i2c
);
    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_CYC - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [15:0]      RST_TICKS = 16'(RESET_TICKS);

    typedef enum logic [3:0] {
        IDLE, RST_HOLD, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERROR
`ifdef CAM_INIT_READBACK_EN
        , VERIFY_ISSUE, VERIFY_WAIT
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic [RW-1:0]    retry_reg, retry_next;
    logic [PW-1:0]    presc_reg;
    logic [15:0]      dly_reg, dly_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic [IDX_W-1:0] err_index_reg, err_index_next;
    logic             cam_reset_n_reg, cam_reset_n_next;
    logic [15:0]      reg_addr_reg, reg_addr_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic             tick, advance, fail;
    logic             unused_bits;

    assign tick = (presc_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            retry_reg       <= '0;
            presc_reg       <= '0;
            dly_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            err_index_reg   <= '0;
            cam_reset_n_reg <= 1'b0;
            reg_addr_reg    <= '0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            retry_reg       <= retry_next;
            dly_reg         <= dly_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            err_index_reg   <= err_index_next;
            cam_reset_n_reg <= cam_reset_n_next;
            reg_addr_reg    <= reg_addr_next;
            wdata_reg       <= wdata_next;
            // Tick phase is relative to state entry so every hold/delay lasts whole ticks.
            if (state_next != state_reg || tick)
                presc_reg <= '0;
            else
                presc_reg <= presc_reg + 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        retry_next       = retry_reg;
        dly_next         = dly_reg;
        busy_next        = busy_reg;
        done_next        = done_reg;
        error_next       = error_reg;
        err_index_next   = err_index_reg;
        cam_reset_n_next = cam_reset_n_reg;
        reg_addr_next    = reg_addr_reg;
        wdata_next       = wdata_reg;
        advance          = 1'b0;
        fail             = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                state_next       = RST_HOLD;
                busy_next        = 1'b1;
                done_next        = 1'b0;
                error_next       = 1'b0;
                cam_reset_n_next = 1'b0;
                index_next       = '0;
                retry_next       = '0;
                dly_next         = RST_TICKS;
            end
            RST_HOLD: if (tick) begin
                if (dly_reg <= 16'd1) begin
                    cam_reset_n_next = 1'b1;
                    state_next       = FETCH;
                end else begin
                    dly_next = dly_reg - 16'd1;
                end
            end
            FETCH: state_next = DECODE;
            DECODE: begin
                reg_addr_next = tbl_data[23:8];
                wdata_next    = tbl_data[7:0];
                if (tbl_data[31]) begin
                    state_next = DONE;
                end else if (tbl_data[30]) begin
                    state_next = DELAY;
                    dly_next   = tbl_data[15:0];
                end else begin
                    state_next = ISSUE;
                end
            end
            ISSUE: if (i2c.cmd_ready) state_next = WAIT_RSP;
            WAIT_RSP: if (i2c.rsp_valid) begin
                if (i2c.rsp_nack)
                    fail = 1'b1;
                else
`ifdef CAM_INIT_READBACK_EN
                    state_next = VERIFY_ISSUE;
`else
                    advance = 1'b1;
`endif
            end
`ifdef CAM_INIT_READBACK_EN
            VERIFY_ISSUE: if (i2c.cmd_ready) state_next = VERIFY_WAIT;
            VERIFY_WAIT: if (i2c.rsp_valid) begin
                if (i2c.rsp_nack || i2c.rsp_rdata != wdata_reg)
                    fail = 1'b1;
                else
                    advance = 1'b1;
            end
`endif
            DELAY: begin
                if (dly_reg == 16'd0)
                    advance = 1'b1;
                else if (tick)
                    dly_next = dly_reg - 16'd1;
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            ERROR: begin
                error_next = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A failed attempt restarts at the write, so a bad readback re-sends the write too.
        if (fail) begin
            if (retry_reg < RETRY_MAX) begin
                retry_next = retry_reg + 1'b1;
                state_next = ISSUE;
            end else begin
                err_index_next = index_reg;
                state_next     = ERROR;
            end
        end
        if (advance) begin
            retry_next = '0;
            if (index_reg == LAST_IDX) begin
                state_next = DONE;
            end else begin
                index_next = index_reg + 1'b1;
                state_next = FETCH;
            end
        end
    end

`ifdef CAM_INIT_READBACK_EN
    assign i2c.cmd_valid = (state_reg == ISSUE) || (state_reg == VERIFY_ISSUE);
    assign i2c.cmd_rd    = (state_reg == VERIFY_ISSUE);
`else
    assign i2c.cmd_valid = (state_reg == ISSUE);
    assign i2c.cmd_rd    = 1'b0;
`endif
    assign i2c.cmd_dev   = DEV_ADDR;
    assign i2c.cmd_reg   = reg_addr_reg;
    assign i2c.cmd_wdata = wdata_reg;

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
    assign err_index   = err_index_reg;
    assign cam_reset_n = cam_reset_n_reg;
    assign tbl_addr    = index_reg;

    assign unused_bits = ^{tbl_data[29:24], i2c.rsp_rdata};
endmodule
